// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: state encoding and configuration legality check for the uart TX arbiter.
package uart_tx_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;
  function automatic bit cfg_ok(int n, int iw);
    return n >= 2 && n <= 8 && iw >= $clog2(n);
  endfunction
endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// rr_pick: rotating-priority search; the first requester after `last` (mod N) wins.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] idx
);
  always_comb begin
    int best;
    int d;
    any  = 1'b0;
    idx  = '0;
    best = N;
    d    = 0;
    // d is the distance from last+1 going round the ring; smallest distance wins
    for (int i = 0; i < N; i++) begin
      d = (i + N - 1 - int'(last)) % N;
      if (req[i] && d < best) begin
        best = d;
        idx  = IW'(i);
        any  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin sharing of one uart transmitter between N byte requesters,
// sequencing each byte with a four-phase send/done handshake.
module uart_tx_arb import uart_tx_arb_pkg::*; #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] data,
  output logic [N-1:0]   ack,
  output logic           busy,
  output logic [IW-1:0]  owner,
  output logic [7:0]     uart_din,
  output logic           uart_send,
  input  logic           uart_done
);
  if (!cfg_ok(N, IW)) begin : g_bad_cfg
    $error("uart_tx_arb: need 2 <= N <= 8 and IW >= clog2(N)");
  end
  state_e        state_q, state_d;
  logic [IW-1:0] last_q, last_d, owner_q, owner_d, idx;
  logic [7:0]    din_q, din_d, pick;
  logic [N-1:0]  ack_q, ack_d;
  logic          any;
  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req  (req),
    .last (last_q),
    .any  (any),
    .idx  (idx)
  );
  always_comb begin
    pick = '0;
    for (int i = 0; i < N; i++) pick = (IW'(i) == idx) ? data[8*i +: 8] : pick;
  end
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    din_d   = din_q;
    ack_d   = '0;
    case (state_q)
      ST_IDLE: if (any && !uart_done) begin
        state_d = ST_SEND;
        owner_d = idx;
        din_d   = pick;
      end
      ST_SEND: if (uart_done) begin
        state_d = ST_RELEASE;
        last_d  = owner_q;
        for (int i = 0; i < N; i++) ack_d[i] = (IW'(i) == owner_q);
      end
      ST_RELEASE: state_d = uart_done ? ST_RELEASE : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= IW'(N - 1);
      owner_q <= '0;
      din_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
    end
  end
  // busy and send are decodes of the state register, so they stay free of input paths
  assign busy      = state_q != ST_IDLE;
  assign uart_send = state_q == ST_SEND;
  assign ack       = ack_q;
  assign owner     = owner_q;
  assign uart_din  = din_q;
endmodule
